// File: rtl/dsp_mac_slice.sv
// Parametrised MAC slice: pre-adder, unsigned multiplier and post-adder/accumulator
// with optional input/multiplier registers, a valid pipeline, sticky overflow and saturation.
module dsp_mac_slice #(
   parameter int    AW         = 18,
   parameter int    BW         = 18,
   parameter int    PW         = 48,
   parameter int    IREG       = 1,
   parameter int    MREG       = 1,
   parameter string CARRYINSEL = "OPMODE5",
   parameter int    SATURATE   = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE,
   input  logic             IN_VALID,
   input  logic [AW-1:0]    A,
   input  logic [BW-1:0]    B,
   input  logic [BW-1:0]    D,
   input  logic [PW-1:0]    C,
   input  logic [PW-1:0]    PCIN,
   input  logic             CARRYIN,
   input  logic [7:0]       OPMODE,
   output logic [AW+BW-1:0] M,
   output logic [PW-1:0]    P,
   output logic [PW-1:0]    PCOUT,
   output logic             CARRYOUT,
   output logic             OVERFLOW,
   output logic             OUT_VALID
);

   localparam int MW          = AW + BW;
   localparam int DABW        = 2*BW + AW;
   localparam bit USE_CIN_PIN = (CARRYINSEL == "CARRYIN");

   typedef struct packed {
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic [BW-1:0] d;
      logic [PW-1:0] c;
      logic [PW-1:0] pcin;
      logic          cin;
      logic [7:0]    op;
      logic          vld;
   } s1_t;

   // Only the opmode bits still needed after the multiplier are carried forward.
   typedef struct packed {
      logic [MW-1:0]   m;
      logic [DABW-1:0] dab;
      logic [PW-1:0]   c;
      logic [PW-1:0]   pcin;
      logic            cin;
      logic            sub;
      logic [1:0]      zsel;
      logic [1:0]      xsel;
      logic            vld;
   } s2_t;

   function automatic logic [BW-1:0] pre_add(input logic [7:0] op, input logic [BW-1:0] b,
                                             input logic [BW-1:0] d);
      if (!op[4])
         return b;
      else if (op[6])
         return d - b;
      else
         return d + b;
   endfunction

   function automatic logic [PW-1:0] sat_result(input logic [PW:0] r, input logic sub);
      if ((SATURATE != 0) && r[PW])
         return sub ? '0 : '1;
      return r[PW-1:0];
   endfunction

   s1_t in_p0;
   s1_t stg_p1;
   s2_t s2_in;
   s2_t stg_p2;

   logic [PW-1:0] p_d, p_q;
   logic          carryout_d, carryout_q;
   logic          overflow_d, overflow_q;
   logic          out_valid_d, out_valid_q;
   logic [PW-1:0] x_p2, z_p2, res_p2;
   logic [PW:0]   r_p2;

   always_comb begin
      in_p0.a    = A;
      in_p0.b    = B;
      in_p0.d    = D;
      in_p0.c    = C;
      in_p0.pcin = PCIN;
      in_p0.cin  = CARRYIN;
      in_p0.op   = OPMODE;
      in_p0.vld  = IN_VALID;
   end

   // ---- S1: input register ----
   generate
      if (IREG != 0) begin : g_ireg
         s1_t stg_p1_d, stg_p1_q;
         always_comb stg_p1_d = CE ? in_p0 : stg_p1_q;
         always_ff @(posedge CLK) begin
            if (RST)
               stg_p1_q <= '0;
            else
               stg_p1_q <= stg_p1_d;
         end
         assign stg_p1 = stg_p1_q;
      end else begin : g_no_ireg
         assign stg_p1 = in_p0;
      end
   endgenerate

   always_comb begin
      s2_in.m    = MW'(stg_p1.a) * MW'(pre_add(stg_p1.op, stg_p1.b, stg_p1.d));
      s2_in.dab  = {stg_p1.d, stg_p1.a, stg_p1.b};
      s2_in.c    = stg_p1.c;
      s2_in.pcin = stg_p1.pcin;
      s2_in.cin  = USE_CIN_PIN ? stg_p1.cin : stg_p1.op[5];
      s2_in.sub  = stg_p1.op[7];
      s2_in.zsel = stg_p1.op[3:2];
      s2_in.xsel = stg_p1.op[1:0];
      s2_in.vld  = stg_p1.vld;
   end

   // ---- S2: multiplier register ----
   generate
      if (MREG != 0) begin : g_mreg
         s2_t stg_p2_d, stg_p2_q;
         always_comb stg_p2_d = CE ? s2_in : stg_p2_q;
         always_ff @(posedge CLK) begin
            if (RST)
               stg_p2_q <= '0;
            else
               stg_p2_q <= stg_p2_d;
         end
         assign stg_p2 = stg_p2_q;
      end else begin : g_no_mreg
         assign stg_p2 = s2_in;
      end
   endgenerate

   // Post-adder in PW+1 bits; bit PW is the carry (add) or borrow (subtract).
   always_comb begin
      x_p2 = '0;
      case (stg_p2.xsel)
         2'd1:    x_p2 = PW'(stg_p2.m);
         2'd2:    x_p2 = p_q;
         2'd3:    x_p2 = PW'(stg_p2.dab);
         default: x_p2 = '0;
      endcase
      z_p2 = '0;
      case (stg_p2.zsel)
         2'd1:    z_p2 = stg_p2.pcin;
         2'd2:    z_p2 = p_q;
         2'd3:    z_p2 = stg_p2.c;
         default: z_p2 = '0;
      endcase
      if (stg_p2.sub)
         r_p2 = {1'b0, z_p2} - ({1'b0, x_p2} + {{PW{1'b0}}, stg_p2.cin});
      else
         r_p2 = {1'b0, z_p2} + {1'b0, x_p2} + {{PW{1'b0}}, stg_p2.cin};
      res_p2 = sat_result(r_p2, stg_p2.sub);
   end

   // ---- S3: result register ----
   always_comb begin
      p_d         = p_q;
      carryout_d  = carryout_q;
      overflow_d  = overflow_q;
      out_valid_d = out_valid_q;
      if (CE) begin
         out_valid_d = stg_p2.vld;
         if (stg_p2.vld) begin
            p_d        = res_p2;
            carryout_d = r_p2[PW];
            overflow_d = overflow_q | r_p2[PW];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         p_q         <= '0;
         carryout_q  <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         p_q         <= p_d;
         carryout_q  <= carryout_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign M         = stg_p2.m;
   assign P         = p_q;
   assign PCOUT     = p_q;
   assign CARRYOUT  = carryout_q;
   assign OVERFLOW  = overflow_q;
   assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Scoreboard bench for dsp_mac_slice: three instances (plain, saturating, unregistered with
// CARRYIN carry source) share one stimulus stream; expected results are queued per instance.
module tb_dsp_mac_slice;

   logic        clk = 1'b0;
   logic        rst, ce, in_valid, carryin;
   logic [17:0] a, b, d;
   logic [47:0] c, pcin;
   logic [7:0]  op;

   logic [35:0] m0, m1, m2;
   logic [47:0] p0, p1, p2, pc0, pc1, pc2;
   logic        co0, co1, co2, ov0, ov1, ov2, vo0, vo1, vo2;

   typedef struct {
      logic [47:0] p;
      logic        co;
      logic        ovf;
      int          due;
   } item_t;

   item_t q0[$];
   item_t q1[$];
   item_t q2[$];

   int checks = 0;
   int errors = 0;
   int cnt    = 0;
   bit ovf_m  = 1'b0;
   bit fresh0, fresh1, fresh2;

   always #5 clk = ~clk;

   always @(posedge clk) if (ce) cnt <= cnt + 1;

   dsp_mac_slice #(.IREG(1), .MREG(1), .SATURATE(0)) dut0 (
      .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
      .PCIN(pcin), .CARRYIN(carryin), .OPMODE(op), .M(m0), .P(p0), .PCOUT(pc0),
      .CARRYOUT(co0), .OVERFLOW(ov0), .OUT_VALID(vo0));

   dsp_mac_slice #(.IREG(1), .MREG(1), .SATURATE(1)) dut1 (
      .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
      .PCIN(pcin), .CARRYIN(carryin), .OPMODE(op), .M(m1), .P(p1), .PCOUT(pc1),
      .CARRYOUT(co1), .OVERFLOW(ov1), .OUT_VALID(vo1));

   dsp_mac_slice #(.IREG(0), .MREG(0), .SATURATE(0), .CARRYINSEL("CARRYIN")) dut2 (
      .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .A(a), .B(b), .D(d), .C(c),
      .PCIN(pcin), .CARRYIN(carryin), .OPMODE(op), .M(m2), .P(p2), .PCOUT(pc2),
      .CARRYOUT(co2), .OVERFLOW(ov2), .OUT_VALID(vo2));

   task automatic check_out(input int idx, input logic [47:0] p, input logic [47:0] pc,
                            input logic co, input logic ov);
      item_t e;
      bit    have;
      have = 1'b0;
      case (idx)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL dut%0d unexpected OUT_VALID P=%h", idx, p);
      end else if (p !== e.p || pc !== e.p || co !== e.co || ov !== e.ovf || cnt != e.due) begin
         errors++;
         $display("FAIL dut%0d result P=%h PCOUT=%h CO=%b OVF=%b cycle=%0d required P=%h CO=%b OVF=%b cycle=%0d",
                  idx, p, pc, co, ov, cnt, e.p, e.co, e.ovf, e.due);
      end
   endtask

   always @(posedge clk) begin
      fresh0 = ce && !rst;
      #1;
      if (fresh0 && vo0) check_out(0, p0, pc0, co0, ov0);
   end

   always @(posedge clk) begin
      fresh1 = ce && !rst;
      #1;
      if (fresh1 && vo1) check_out(1, p1, pc1, co1, ov1);
   end

   always @(posedge clk) begin
      fresh2 = ce && !rst;
      #1;
      if (fresh2 && vo2) check_out(2, p2, pc2, co2, ov2);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic chk_zero_all(input string nm);
      chk({nm, " dut0 P"}, 64'(p0), 64'd0);
      chk({nm, " dut0 M"}, 64'(m0), 64'd0);
      chk({nm, " dut0 OVF/VLD/CO"}, {61'd0, ov0, vo0, co0}, 64'd0);
      chk({nm, " dut1 P"}, 64'(p1), 64'd0);
      chk({nm, " dut1 M"}, 64'(m1), 64'd0);
      chk({nm, " dut1 OVF/VLD/CO"}, {61'd0, ov1, vo1, co1}, 64'd0);
      chk({nm, " dut2 P"}, 64'(p2), 64'd0);
      chk({nm, " dut2 OVF/VLD/CO"}, {61'd0, ov2, vo2, co2}, 64'd0);
   endtask

   // Drives one valid sample at a negedge and queues its expected result per instance.
   task automatic issue(input logic [17:0] ia, input logic [17:0] ib, input logic [17:0] id,
                        input logic [47:0] ic, input logic [47:0] ipc, input logic icin,
                        input logic [7:0] iop, input logic [47:0] e0, input logic [47:0] e1,
                        input logic [47:0] e2, input logic eco);
      a = ia; b = ib; d = id; c = ic; pcin = ipc; carryin = icin; op = iop;
      in_valid = 1'b1;
      ovf_m = ovf_m | eco;
      q0.push_back(item_t'{p: e0, co: eco, ovf: ovf_m, due: cnt + 3});
      q1.push_back(item_t'{p: e1, co: eco, ovf: ovf_m, due: cnt + 3});
      q2.push_back(item_t'{p: e2, co: eco, ovf: ovf_m, due: cnt + 1});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      while ((q0.size() + q1.size() + q2.size()) > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ((q0.size() + q1.size() + q2.size()) > 0) begin
         errors++;
         $display("FAIL drain timeout pending=%0d/%0d/%0d required 0/0/0",
                  q0.size(), q1.size(), q2.size());
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      q0.delete(); q1.delete(); q2.delete();
      ovf_m = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ce = 1'b1; in_valid = 1'b1; carryin = 1'b1;
      a = 18'd7; b = 18'd9; d = 18'd3; c = 48'd123; pcin = 48'd55; op = 8'h0D;

      // reset held with busy inputs
      repeat (5) begin
         @(negedge clk);
         chk_zero_all("reset");
      end
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk_zero_all("post-reset");

      // pre-adder then subtract: M = 4*(15+10) = 100, P = 150-100
      reset_dut();
      issue(18'd4, 18'd10, 18'd15, 48'd150, 48'd0, 1'b0, 8'h9D, 48'd50, 48'd50, 48'd50, 1'b0);
      chk("preadd dut2 M", 64'(m2), 64'd100);
      idle(1);
      chk("preadd dut0 M", 64'(m0), 64'd100);
      chk("preadd dut1 M", 64'(m1), 64'd100);
      drain();

      // accumulate 15 per sample with a 3-cycle CE freeze after two samples
      reset_dut();
      issue(18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 1'b0, 8'h09, 48'd15, 48'd15, 48'd15, 1'b0);
      issue(18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 1'b0, 8'h09, 48'd30, 48'd30, 48'd30, 1'b0);
      ce = 1'b0;
      in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("freeze dut0 P", 64'(p0), 64'd0);
         chk("freeze dut0 VLD", 64'(vo0), 64'd0);
         chk("freeze dut2 P", 64'(p2), 64'd30);
         chk("freeze dut2 VLD", 64'(vo2), 64'd1);
      end
      ce = 1'b1;
      issue(18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 1'b0, 8'h09, 48'd45, 48'd45, 48'd45, 1'b0);
      issue(18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 1'b0, 8'h09, 48'd60, 48'd60, 48'd60, 1'b0);
      drain();
      idle(3);
      chk("hold dut0 P", 64'(p0), 64'd60);
      chk("hold dut1 P", 64'(p1), 64'd60);
      chk("hold dut2 P", 64'(p2), 64'd60);
      chk("hold dut0 VLD", 64'(vo0), 64'd0);

      // reset with samples in flight
      reset_dut();
      issue(18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 1'b0, 8'h09, 48'd15, 48'd15, 48'd15, 1'b0);
      issue(18'd3, 18'd5, 18'd0, 48'd0, 48'd0, 1'b0, 8'h09, 48'd30, 48'd30, 48'd30, 1'b0);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk_zero_all("midreset");
      rst = 1'b0;
      q0.delete(); q1.delete(); q2.delete();
      ovf_m = 1'b0;
      idle(6);
      chk("midreset dut0 P stays", 64'(p0), 64'd0);

      // saturating add / subtract, then a clean result with sticky overflow
      reset_dut();
      issue(18'd10, 18'd10, 18'd0, 48'hFFFF_FFFF_FFF6, 48'd0, 1'b0, 8'h0D,
            48'd90, 48'hFFFF_FFFF_FFFF, 48'd90, 1'b1);
      issue(18'd4, 18'd5, 18'd0, 48'd5, 48'd0, 1'b0, 8'h8D,
            48'hFFFF_FFFF_FFF1, 48'd0, 48'hFFFF_FFFF_FFF1, 1'b1);
      issue(18'd4, 18'd10, 18'd15, 48'd150, 48'd0, 1'b0, 8'h9D, 48'd50, 48'd50, 48'd50, 1'b0);

      // carry source, X/Z mux corners, pre-subtract wrap, P+P feedback
      issue(18'd2, 18'd3, 18'd0, 48'd7, 48'd0, 1'b1, 8'h0D, 48'd13, 48'd13, 48'd14, 1'b0);
      issue(18'd2, 18'd3, 18'd0, 48'd7, 48'd0, 1'b0, 8'h2D, 48'd14, 48'd14, 48'd13, 1'b0);
      issue(18'd2, 18'd3, 18'd1, 48'd0, 48'd0, 1'b0, 8'h03,
            48'd68720001027, 48'd68720001027, 48'd68720001027, 1'b0);
      issue(18'd2, 18'd3, 18'd0, 48'd0, 48'd1000, 1'b0, 8'h05, 48'd1006, 48'd1006, 48'd1006, 1'b0);
      issue(18'd1, 18'd5, 18'd3, 48'd0, 48'd0, 1'b0, 8'h51, 48'd262142, 48'd262142, 48'd262142, 1'b0);
      issue(18'd0, 18'd0, 18'd0, 48'd0, 48'd0, 1'b0, 8'h0A, 48'd524284, 48'd524284, 48'd524284, 1'b0);

      // invalid samples with live data must not disturb P
      in_valid = 1'b0;
      c = 48'd999;
      op = 8'h0D;
      drain();
      idle(3);
      chk("invalid hold dut0 P", 64'(p0), 64'd524284);
      chk("invalid hold dut2 P", 64'(p2), 64'd524284);
      chk("sticky dut1 OVF", 64'(ov1), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
